// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a framed byte stream into
// big-endian instruction-word writes and releases the CPU once the
// trailing XOR checksum matches.
module imem_loader #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [BIT_WIDTH-1:0]  o_wr_data,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned CNT_W   = 17;
  localparam int unsigned SHIFT_W = BIT_WIDTH - 8;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [7:0]            r_cnt_hi;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_words;
  logic [1:0]            r_byte_idx;
  logic [7:0]            r_csum;
  logic [SHIFT_W-1:0]    r_shift;
  logic                  r_rx_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [BIT_WIDTH-1:0]  r_wr_data;
  logic                  r_cpu_rst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_words_next;

  // Byte handshake, 17-bit word count and next words-written value.
  assign w_accept     = i_rx_valid && r_rx_ready;
  assign w_count      = {1'b0, r_cnt_hi, i_rx_data};
  assign w_words_next = CNT_W'(r_words + CNT_W'(1));

  // Frame FSM with registered handshake, write-port and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cnt_hi   <= '0;
      r_count    <= '0;
      r_words    <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
      r_shift    <= '0;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_rst  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      // Advance the address after each write except the last one, so it never wraps.
      if (r_wr_en && (r_words != r_count)) begin
        r_wr_addr <= ADDR_WIDTH'(r_wr_addr + ADDR_WIDTH'(1));
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_CNT_HI;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_wr_addr  <= '0;
            r_byte_idx <= '0;
            r_words    <= '0;
            r_csum     <= '0;
            r_err      <= 1'b0;
            r_cpu_rst  <= 1'b0;
          end
        end

        S_CNT_HI: begin
          if (w_accept) begin
            r_cnt_hi <= i_rx_data;
            r_state  <= S_CNT_LO;
          end
        end

        S_CNT_LO: begin
          if (w_accept) begin
            if ((w_count == '0) || (w_count > DEPTH)) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_count <= w_count;
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ i_rx_data;
            r_byte_idx <= 2'(r_byte_idx + 2'd1);
            if (r_byte_idx == 2'd3) begin
              r_wr_data <= {r_shift, i_rx_data};
              r_wr_en   <= 1'b1;
              r_words   <= w_words_next;
              if (w_words_next == r_count) begin
                r_state <= S_CSUM;
              end
            end else begin
              r_shift <= {r_shift[SHIFT_W-9:0], i_rx_data};
            end
          end
        end

        S_CSUM: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_cpu_rst  = r_cpu_rst;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames checked every cycle against a
// frame-position reference model, plus literal checks on captured memory.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.BIT_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_cpu_rst  (cpu_rst),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the frame, not the DUT state.
  bit          m_on = 0;
  bit          m_busy, m_err, m_cpu_rst, m_done, m_wr_en, m_rst_vals;
  int          m_pos, m_n, m_addr;
  logic [7:0]  m_hi, m_csum;
  logic [31:0] m_word, m_data;

  always @(posedge clk) begin
    m_wr_en = 0;
    m_done  = 0;
    if (!rst) begin
      m_on = 1; m_busy = 0; m_err = 0; m_cpu_rst = 0; m_rst_vals = 1;
    end else if (start && !m_busy) begin
      m_busy = 1; m_pos = 0; m_csum = 0; m_err = 0; m_cpu_rst = 0; m_rst_vals = 0;
    end else if (m_busy && rx_valid) begin
      if (m_pos == 0) begin
        m_hi = rx_data;
      end else if (m_pos == 1) begin
        m_n = {16'd0, m_hi, rx_data};
        if (m_n == 0 || m_n > 64) begin
          m_err = 1; m_busy = 0;
        end
      end else if (m_pos < 2 + 4 * m_n) begin
        m_csum = m_csum ^ rx_data;
        m_word = {m_word[23:0], rx_data};
        if ((m_pos - 2) % 4 == 3) begin
          m_wr_en = 1;
          m_addr  = (m_pos - 2) / 4;
          m_data  = m_word;
        end
      end else begin
        m_busy = 0;
        if (rx_data == m_csum) begin
          m_done = 1; m_cpu_rst = 1;
        end else begin
          m_err = 1;
        end
      end
      m_pos++;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("rx_ready", 32'(rx_ready), 32'(m_busy));
      chk("busy",     32'(busy),     32'(m_busy));
      chk("wr_en",    32'(wr_en),    32'(m_wr_en));
      chk("done",     32'(done),     32'(m_done));
      chk("err",      32'(err),      32'(m_err));
      chk("cpu_rst",  32'(cpu_rst),  32'(m_cpu_rst));
      if (m_wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", wr_data, m_data);
      end
      if (m_rst_vals) begin
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
      end
    end
  end

  // Capture of what the DUT actually wrote into program memory.
  logic [31:0] dmem [0:63];
  int          wr_count = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      dmem[wr_addr] = wr_data;
      wr_count++;
    end
  end

  logic [7:0]  tx_q [$];
  logic [31:0] exp_words [0:127];
  logic [31:0] fixed_w [0:1];
  logic [7:0]  last_csum;

  // Build a frame: count header, words (fixed or random), checksum.
  task automatic build_frame(input int n, input bit use_fixed, input int csum_ovr);
    logic [31:0] w;
    logic [7:0]  cs;
    logic [15:0] nn;
    cs = 8'h00;
    nn = 16'(n);
    tx_q.delete();
    tx_q.push_back(nn[15:8]);
    tx_q.push_back(nn[7:0]);
    for (int k = 0; k < n; k++) begin
      w = use_fixed ? fixed_w[k] : $urandom;
      exp_words[k] = w;
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    last_csum = cs;
    tx_q.push_back(csum_ovr >= 0 ? 8'(csum_ovr) : cs);
  endtask

  // Start pulse then stream the frame; stall 0=none 1=alternate 2=random.
  task automatic run_frame(input int stall, input int start_at, input int rst_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == rst_at) begin
        rx_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        return;
      end
      if (stall == 1 || (stall == 2 && $urandom_range(0, 2) == 0)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      start    = (i == start_at);
      @(negedge clk);
      start = 1'b0;
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int wc0;

  initial begin
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    fixed_w[0] = 32'h20080005;
    fixed_w[1] = 32'hAC080000;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cpu_rst", 32'(cpu_rst), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean load, no stalls.
    build_frame(2, 1'b1, -1);
    wc0 = wr_count;
    run_frame(0, -1, -1);
    chk("clean_mem0", dmem[0], 32'h20080005);
    chk("clean_mem1", dmem[1], 32'hAC080000);
    chk("clean_writes", 32'(wr_count - wc0), 32'd2);
    chk("clean_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("clean_err", 32'(err), 32'd0);

    // Same frame with valid toggled every other cycle.
    wc0 = wr_count;
    run_frame(1, -1, -1);
    chk("stall_writes", 32'(wr_count - wc0), 32'd2);
    chk("stall_mem1", dmem[1], 32'hAC080000);

    // Bad checksum, then recovery with a correct frame.
    fixed_w[0] = 32'h12345678;
    build_frame(1, 1'b1, 0);
    chk("csum_ref", 32'(last_csum), 32'h08);
    wc0 = wr_count;
    run_frame(0, -1, -1);
    chk("bad_writes", 32'(wr_count - wc0), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_cpu_rst", 32'(cpu_rst), 32'd0);
    build_frame(1, 1'b1, -1);
    run_frame(0, -1, -1);
    chk("recover_err", 32'(err), 32'd0);
    chk("recover_cpu_rst", 32'(cpu_rst), 32'd1);

    // Count bounds: 0 and 65 rejected, 64 accepted.
    build_frame(0, 1'b0, -1);
    wc0 = wr_count;
    run_frame(0, -1, -1);
    chk("n0_writes", 32'(wr_count - wc0), 32'd0);
    chk("n0_err", 32'(err), 32'd1);
    build_frame(65, 1'b0, -1);
    wc0 = wr_count;
    run_frame(2, -1, -1);
    chk("n65_writes", 32'(wr_count - wc0), 32'd0);
    chk("n65_err", 32'(err), 32'd1);
    build_frame(64, 1'b0, -1);
    wc0 = wr_count;
    run_frame(2, -1, -1);
    chk("n64_writes", 32'(wr_count - wc0), 32'd64);
    for (int k = 0; k < 64; k++) chk("n64_mem", dmem[k], exp_words[k]);
    chk("n64_cpu_rst", 32'(cpu_rst), 32'd1);

    // Start pulsed during DATA is ignored.
    build_frame(3, 1'b0, -1);
    run_frame(0, 5, -1);
    chk("midstart_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midstart_mem2", dmem[2], exp_words[2]);

    // Reset after 6 payload bytes.
    build_frame(3, 1'b0, -1);
    wc0 = wr_count;
    run_frame(0, -1, 8);
    chk("rst_writes", 32'(wr_count - wc0), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Random frames, some with corrupted checksum.
    for (int r = 0; r < 8; r++) begin
      build_frame(int'($urandom_range(1, 8)), 1'b0,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1);
      run_frame(2, ($urandom_range(0, 1) == 1) ? 4 : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the pipelined datapath fetches from. Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive word addresses of program memory. A trailing XOR checksum verifies the stream. The CPU is held in reset until a load completes cleanly.

## Interface
- BIT_WIDTH, 32, instruction word width; fixed at 4 bytes.
- ADDR_WIDTH, 6, program memory word-address width (depth 2^ADDR_WIDTH); legal range 1..16.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  program memory write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  program memory word address.
- wr_data  out  BIT_WIDTH  assembled instruction word.
- cpu_rst  out  1  active-low reset to the datapath; low = CPU held.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared by start or rst.

## Operation
- Frame: CNT_HI, CNT_LO (16-bit big-endian word count N), then 4N payload bytes (MSB first per word), then one checksum byte equal to the XOR of all 4N payload bytes.
- A byte transfers on a rising edge with rx_valid && rx_ready. rx_data is ignored otherwise.
- States:
  - IDLE: rx_ready=0. start -> CNT_HI.
  - CNT_HI: accept the high byte -> CNT_LO.
  - CNT_LO: accept the low byte, then check the count.
    - N==0 or N>2^ADDR_WIDTH -> ERR.
    - Otherwise -> DATA.
    - Compare in 17 bits.
  - DATA: shift each byte into the word register.
    - On the 4th byte of a word, register wr_data and assert wr_en for one cycle at the current wr_addr.
    - wr_addr then increments.
    - After word N -> CSUM.
  - CSUM: accept one byte. Match -> DONE with a done pulse; mismatch -> ERR.
  - DONE: rx_ready=0, cpu_rst=1. start -> CNT_HI.
  - ERR: rx_ready=0, err=1, cpu_rst=0. start -> CNT_HI.
- rx_ready=1 in CNT_HI, CNT_LO, DATA and CSUM.
- busy=1 in CNT_HI through CSUM.
- On start, in the same edge:
  - wr_addr=0.
  - Byte-in-word counter=0.
  - Words-written counter=0.
  - Running checksum=0.
  - err=0.
  - cpu_rst=0.
- Running checksum: XOR of payload bytes only; the header and checksum bytes are excluded.
- Words written before an error stay in memory; there is no rollback. The CPU stays in reset until a clean load.
- start while busy is ignored.
- wr_addr never wraps: N≤2^ADDR_WIDTH is enforced, and the final increment is not used for a write.

## Timing
- Reset values:
  - rx_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_rst=0, busy=0, done=0, err=0.
  - State IDLE.
- Reset mid-load returns to IDLE with the reset values above. Partial memory contents are untouched.
- start at edge k gives busy=1 and rx_ready=1 from cycle k+1.
- Word write: the 4th byte is accepted at edge t. wr_en=1 with valid wr_addr/wr_data during cycle t+1 (registered).
- No backpressure inside a frame: rx_ready stays 1 every cycle until the frame ends. Throughput is 1 byte/cycle.
- Checksum byte accepted at edge c:
  - Success: done=1 for cycle c+1 only; busy=0 and cpu_rst=1 from c+1.
  - Failure: err=1 and busy=0 from c+1.
- Bad count accepted at edge c: err=1 and rx_ready=0 from c+1.
- Minimum frame time: 2+4N+1 accepted bytes.

## Test plan
- **Clean load, no stalls.** N=2, words 0x20080005, 0xAC080000, checksum 0x00^… (computed), rx_valid held high.
  - Expect wr_en at wr_addr 0 then 1 with those exact words.
  - Expect a done pulse, cpu_rst=1, err=0.
- **Stalled valid.** Same frame with rx_valid toggled every other cycle.
  - Expect identical writes, spaced by the stalls.
  - Expect no write on idle cycles.
- **Bad checksum.** N=1, word 0x12345678, checksum 0x00 (correct is 0x00^0x12^0x34^0x56^0x78=0x08).
  - Expect one write at address 0, then err=1, cpu_rst=0, no done.
  - Then start plus a correct frame: err clears and done pulses.
- **Count bounds.**
  - N=0: ERR after CNT_LO, no writes.
  - N=65 with ADDR_WIDTH=6: ERR, no writes.
  - N=64: 64 writes at addresses 0..63, then done.
- **Mid-load reset and ignored start.**
  - rst=0 after 6 payload bytes: all outputs return to reset values and there are no further writes.
  - start pulsed during DATA: no effect on counters or address.
